// File: rtl/mem_access_unit.sv
// RV64I memory-stage load/store unit: one doubleword-aligned req/ack bus
// transaction per legal access, with store lane formatting and load extension.

// One byte lane of store formatting: picks the replicated source byte and
// decides whether this lane falls inside the naturally aligned access.
module mem_access_lane #(
    parameter int LANE = 0
) (
    input  logic [1:0]  size,
    input  logic [2:0]  offset,
    input  logic [63:0] data,
    output logic [7:0]  lane_byte,
    output logic        lane_be
);
    localparam logic [2:0] IDX = 3'(LANE);

    logic [2:0] mask;

    always_comb begin
        case (size)
            2'd0:    mask = 3'b000;
            2'd1:    mask = 3'b001;
            2'd2:    mask = 3'b011;
            default: mask = 3'b111;
        endcase
    end

    assign lane_byte = data[{IDX & mask, 3'b000} +: 8];
    // Address is already known aligned, so the access covers lanes whose
    // size-aligned base equals the offset.
    assign lane_be   = ((IDX & ~mask) == offset);
endmodule

module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead_M,
    input  logic        MemWrite_M,
    input  logic [2:0]  Funct3_M,
    input  logic [63:0] ALUResult_M,
    input  logic [63:0] WriteData_M,
    output logic [63:0] ReadData_M,
    output logic        Stall_M,
    output logic        AccessFault_M,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_be,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata
);
    localparam int NUM_LANES = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [2:0]  off_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  be_q;

    logic        access;
    logic        misalign;
    logic        bad_f3;
    logic        start;
    logic        busy;
    logic [63:0] fmt_wdata;
    logic [7:0]  fmt_be;
    logic [63:0] shifted;
    logic [63:0] load_ext;

    assign access = MemRead_M ^ MemWrite_M;

    always_comb begin
        case (Funct3_M[1:0])
            2'd1:    misalign = ALUResult_M[0];
            2'd2:    misalign = |ALUResult_M[1:0];
            2'd3:    misalign = |ALUResult_M[2:0];
            default: misalign = 1'b0;
        endcase
    end

    assign bad_f3 = (MemRead_M & (Funct3_M == 3'b111)) | (MemWrite_M & Funct3_M[2]);

    assign AccessFault_M = (MemRead_M & MemWrite_M) | (access & (misalign | bad_f3));
    assign start         = (state == IDLE) & access & ~AccessFault_M;
    assign busy          = (state == BUSY);
    assign Stall_M       = start | busy;

    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_lane
            mem_access_lane #(.LANE(i)) u_lane (
                .size      (Funct3_M[1:0]),
                .offset    (ALUResult_M[2:0]),
                .data      (WriteData_M),
                .lane_byte (fmt_wdata[8*i +: 8]),
                .lane_be   (fmt_be[i])
            );
        end
    endgenerate

    assign shifted = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (f3_q)
            3'b000:  load_ext = {{56{shifted[7]}},  shifted[7:0]};
            3'b001:  load_ext = {{48{shifted[15]}}, shifted[15:0]};
            3'b010:  load_ext = {{32{shifted[31]}}, shifted[31:0]};
            3'b100:  load_ext = {56'd0, shifted[7:0]};
            3'b101:  load_ext = {48'd0, shifted[15:0]};
            3'b110:  load_ext = {32'd0, shifted[31:0]};
            default: load_ext = shifted;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            f3_q       <= 3'd0;
            off_q      <= 3'd0;
            addr_q     <= 64'd0;
            wdata_q    <= 64'd0;
            be_q       <= 8'd0;
            ReadData_M <= 64'd0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    we_q    <= MemWrite_M;
                    f3_q    <= Funct3_M;
                    off_q   <= ALUResult_M[2:0];
                    addr_q  <= {ALUResult_M[63:3], 3'b000};
                    wdata_q <= MemWrite_M ? fmt_wdata : 64'd0;
                    be_q    <= MemWrite_M ? fmt_be : 8'd0;
                    state   <= BUSY;
                end
                BUSY: if (mem_ack) begin
                    if (!we_q) ReadData_M <= load_ext;
                    state <= DONE;
                end
                // DONE is the cycle the M->W register takes the result.
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_req   = busy;
    assign mem_we    = busy & we_q;
    assign mem_addr  = busy ? addr_q  : 64'd0;
    assign mem_wdata = busy ? wdata_q : 64'd0;
    assign mem_be    = busy ? be_q    : 8'd0;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of legal accesses run through a
// bus responder, plus hand sequences for faults and reset during BUSY.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead_M, MemWrite_M;
    logic [2:0]  Funct3_M;
    logic [63:0] ALUResult_M, WriteData_M;
    logic [63:0] ReadData_M;
    logic        Stall_M, AccessFault_M;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_be;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_rd;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst),
        .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M), .Funct3_M(Funct3_M),
        .ALUResult_M(ALUResult_M), .WriteData_M(WriteData_M),
        .ReadData_M(ReadData_M), .Stall_M(Stall_M), .AccessFault_M(AccessFault_M),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          k;
        logic [63:0] exp_addr;
        logic        exp_we;
        logic [7:0]  exp_be;
        logic [63:0] exp_wdata;
        logic [63:0] exp_load;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wdata);
        MemRead_M   = rd;
        MemWrite_M  = wr;
        Funct3_M    = f3;
        ALUResult_M = addr;
        WriteData_M = wdata;
    endtask

    task automatic run_access(input vec_t v);
        int  stall_cnt;
        int  req_cnt;
        bit  done;
        @(posedge clk); #1;
        drive(v.rd, v.wr, v.f3, v.addr, v.wdata);
        mem_ack   = 1'b0;
        mem_rdata = ~v.rdata;
        @(negedge clk);
        chk("idle_stall", Stall_M, 1);
        chk("idle_noreq", mem_req, 0);
        chk("legal_nofault", AccessFault_M, 0);
        stall_cnt = 1;
        req_cnt   = 0;
        done      = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = ~v.rdata;
            if (Stall_M) stall_cnt++;
            if (mem_req) begin
                req_cnt++;
                chk("req_addr", mem_addr, v.exp_addr);
                chk("req_be", mem_be, v.exp_be);
                chk("req_we", mem_we, v.exp_we);
                if (v.wr) chk("req_wdata", mem_wdata, v.exp_wdata);
                if (req_cnt == v.k + 1) begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.rdata;
                end
            end else begin
                done = 1;
            end
        end
        if (!done) chk("ack_timeout", 0, 1);
        if (v.rd) exp_rd = v.exp_load;
        chk("done_nostall", Stall_M, 0);
        chk("read_data", ReadData_M, exp_rd);
        chk("stall_cycles", 64'(stall_cnt), 64'(v.k + 2));
        chk("req_cycles", 64'(req_cnt), 64'(v.k + 1));
    endtask

    task automatic run_fault(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [63:0] addr);
        @(posedge clk); #1;
        drive(rd, wr, f3, addr, 64'hFFFF_FFFF_FFFF_FFFF);
        repeat (3) begin
            @(negedge clk);
            chk("fault_flag", AccessFault_M, 1);
            chk("fault_noreq", mem_req, 0);
            chk("fault_nostall", Stall_M, 0);
        end
        chk("fault_rd_kept", ReadData_M, exp_rd);
    endtask

    initial begin
        vecs[0]  = '{1, 0, 3'b000, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0,
                     64'h1000, 0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80};
        vecs[1]  = '{0, 1, 3'b010, 64'h2004, 64'hAAAA_BBBB_1234_5678, 64'h0, 0,
                     64'h2000, 1, 8'hF0, 64'h1234_5678_1234_5678, 64'h0};
        vecs[2]  = '{1, 0, 3'b011, 64'h3000, 64'h0, 64'h0123_4567_89AB_CDEF, 3,
                     64'h3000, 0, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF};
        vecs[3]  = '{1, 0, 3'b110, 64'h4004, 64'h0, 64'hDEAD_BEEF_0000_0000, 0,
                     64'h4000, 0, 8'h00, 64'h0, 64'h0000_0000_DEAD_BEEF};
        vecs[4]  = '{0, 1, 3'b000, 64'h5006, 64'h0000_0000_0000_12A5, 64'h0, 1,
                     64'h5000, 1, 8'h40, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0};
        vecs[5]  = '{0, 1, 3'b001, 64'h6002, 64'h0000_0000_0000_BEEF, 64'h0, 2,
                     64'h6000, 1, 8'h0C, 64'hBEEF_BEEF_BEEF_BEEF, 64'h0};
        vecs[6]  = '{1, 0, 3'b101, 64'h7006, 64'h0, 64'h8001_0000_0000_0000, 1,
                     64'h7000, 0, 8'h00, 64'h0, 64'h0000_0000_0000_8001};
        vecs[7]  = '{1, 0, 3'b001, 64'h7006, 64'h0, 64'h8001_0000_0000_0000, 0,
                     64'h7000, 0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001};
        vecs[8]  = '{1, 0, 3'b010, 64'h8004, 64'h0, 64'h8000_0000_0000_0000, 0,
                     64'h8000, 0, 8'h00, 64'h0, 64'hFFFF_FFFF_8000_0000};
        vecs[9]  = '{1, 0, 3'b100, 64'h9007, 64'h0, 64'hFE00_0000_0000_0000, 0,
                     64'h9000, 0, 8'h00, 64'h0, 64'h0000_0000_0000_00FE};
        vecs[10] = '{0, 1, 3'b011, 64'hA000, 64'h1122_3344_5566_7788, 64'h0, 0,
                     64'hA000, 1, 8'hFF, 64'h1122_3344_5566_7788, 64'h0};
        vecs[11] = '{1, 0, 3'b000, 64'hB001, 64'h0, 64'h0000_0000_0000_7F00, 0,
                     64'hB000, 0, 8'h00, 64'h0, 64'h0000_0000_0000_007F};

        rst = 1'b1;
        drive(0, 0, 3'b000, 64'h0, 64'h0);
        mem_ack   = 1'b0;
        mem_rdata = 64'h0;
        exp_rd    = 64'h0;
        #12;
        chk("rst_rd", ReadData_M, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_stall", Stall_M, 0);
        chk("rst_fault", AccessFault_M, 0);
        chk("rst_be", mem_be, 0);
        @(negedge clk);
        rst = 1'b0;

        // Consecutive calls leave no gap: each next access is presented in
        // the IDLE cycle right after the previous DONE (LWU -> SB included).
        foreach (vecs[i]) run_access(vecs[i]);

        run_fault(1, 0, 3'b001, 64'h1001);
        run_fault(1, 0, 3'b111, 64'h1000);
        run_fault(0, 1, 3'b100, 64'h1000);
        run_fault(1, 1, 3'b011, 64'h1000);
        run_fault(1, 0, 3'b011, 64'h3004);
        run_fault(0, 1, 3'b010, 64'h2002);

        // Reset while BUSY, followed by a stray ack.
        @(posedge clk); #1;
        drive(1, 0, 3'b011, 64'h3000, 64'h0);
        @(negedge clk);
        @(negedge clk);
        chk("busy_req", mem_req, 1);
        #2;
        rst = 1'b1;
        drive(0, 0, 3'b000, 64'h0, 64'h0);
        #1;
        chk("rst_busy_req", mem_req, 0);
        chk("rst_busy_stall", Stall_M, 0);
        chk("rst_busy_rd", ReadData_M, 0);
        exp_rd = 64'h0;
        @(negedge clk);
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("stray_ack_req", mem_req, 0);
        chk("stray_ack_stall", Stall_M, 0);
        chk("stray_ack_rd", ReadData_M, exp_rd);
        @(negedge clk);
        chk("stray_ack_rd2", ReadData_M, exp_rd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
